fft_frame_sequencer: RTL and testbench

Sequences audio samples from the DSP front end into fixed-length frames for the shared FFT core. Samples are collected into a ping-pong buffer. Each full bank is streamed to the FFT sink as one packet using valid/ready/sop/eop. The block allows at most one frame in flight: the next frame is not sent until the FFT source reports end of packet. Overflow and FFT error status are reported to the top level.

---
 rtl/fft_seq_pkg.sv | 10 +
 rtl/fft_frame_sequencer_pingpong_ram.sv | 21 ++
 rtl/fft_frame_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_fft_frame_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_seq_pkg.sv
// Shared state types and default sizing for the FFT frame sequencer.
package fft_seq_pkg;

   localparam int unsigned DEF_N_POINTS = 512;
   localparam int unsigned DEF_DATA_W   = 16;

   typedef enum logic [1:0] {S_IDLE, S_PRIME, S_STREAM, S_WAIT_SRC} rd_state_t;
   typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_state_t;

endpackage

// File: rtl/fft_frame_sequencer_pingpong_ram.sv
// Simple dual-port RAM holding both ping-pong banks; address = {bank, addr}.
module pingpong_ram #(
   parameter int unsigned N_POINTS = 512,
   parameter int unsigned DATA_W   = 16
) (
   input  logic                       i_clk,
   input  logic                       i_we,
   input  logic [$clog2(N_POINTS):0]  i_waddr,
   input  logic [DATA_W-1:0]          i_wdata,
   input  logic [$clog2(N_POINTS):0]  i_raddr,
   output logic [DATA_W-1:0]          o_rdata
);

   logic [DATA_W-1:0] mem [2*N_POINTS];

   always_ff @(posedge i_clk) begin
      if (i_we) mem[i_waddr] <= i_wdata;
      o_rdata <= mem[i_raddr];
   end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Collects samples into ping-pong banks and streams each full bank to the FFT core,
// one frame in flight. Optional DROP_COUNT_EN adds a saturating dropped-sample counter.
module fft_frame_sequencer
   import fft_seq_pkg::*;
#(
   parameter int unsigned N_POINTS = DEF_N_POINTS,
   parameter int unsigned DATA_W   = DEF_DATA_W
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_sample_valid,
   input  logic [DATA_W-1:0] i_sample,
   output logic              o_sink_valid,
   input  logic              i_sink_ready,
   output logic              o_sink_sop,
   output logic              o_sink_eop,
   output logic [DATA_W-1:0] o_sink_data,
   input  logic              i_src_valid,
   input  logic              i_src_eop,
   input  logic [1:0]        i_src_error,
   input  logic              i_clr_status,
   output logic              o_frame_done,
   output logic              o_overflow,
   output logic [1:0]        o_fft_error,
   output logic              o_busy
`ifdef DROP_COUNT_EN
   ,
   output logic [15:0]       o_drop_count
`endif
);

   localparam int unsigned       ADDR_W    = $clog2(N_POINTS);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_POINTS - 1);

   rd_state_t         state_q, state_d;
   bank_state_t       bank_q [2];
   bank_state_t       bank_d [2];
   bank_state_t       bank_rel [2];
   logic              rd_bank_q, rd_bank_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic              wr_bank_q, wr_bank_d, wr_bank_eff;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, wr_addr_eff;
   logic              drop_q, drop_d, drop_eff;
   logic              first_full_q, first_full_d;
   logic              frame_done_q, frame_done_d;
   logic              overflow_q, overflow_d;
   logic [1:0]        fft_error_q, fft_error_d;
   logic              release_bank, ram_we, dropped, bank_complete;
   logic              sel_valid, sel_bank;
   logic [DATA_W-1:0] ram_rdata;

   assign release_bank = (state_q == S_STREAM) && i_sink_ready && (rd_addr_q == LAST_ADDR);

   // Write side: a release in this cycle is applied before the write decision.
   always_comb begin
      bank_rel = bank_q;
      if (release_bank) bank_rel[rd_bank_q] = EMPTY;
      drop_eff    = drop_q;
      wr_bank_eff = wr_bank_q;
      wr_addr_eff = wr_addr_q;
      if (drop_q && release_bank) begin
         drop_eff    = 1'b0;
         wr_bank_eff = rd_bank_q;
         wr_addr_eff = '0;
      end
      ram_we        = i_sample_valid && !drop_eff;
      dropped       = i_sample_valid && drop_eff;
      bank_complete = ram_we && (wr_addr_eff == LAST_ADDR);
      bank_d        = bank_rel;
      wr_bank_d     = wr_bank_eff;
      wr_addr_d     = wr_addr_eff;
      drop_d        = drop_eff;
      first_full_d  = first_full_q;
      if (ram_we) begin
         bank_d[wr_bank_eff] = FILLING;
         wr_addr_d           = wr_addr_eff + 1'b1;
         if (bank_complete) begin
            bank_d[wr_bank_eff] = FULL;
            wr_addr_d           = '0;
            first_full_d = (bank_rel[~wr_bank_eff] == FULL) ? ~wr_bank_eff : wr_bank_eff;
            if (bank_rel[~wr_bank_eff] == EMPTY) wr_bank_d = ~wr_bank_eff;
            else                                 drop_d    = 1'b1;
         end
      end
   end

   // A bank completing this cycle counts as full so the frame starts without delay.
   always_comb begin
      sel_valid = 1'b1;
      sel_bank  = 1'b0;
      if (bank_q[0] == FULL && bank_q[1] == FULL) sel_bank = first_full_q;
      else if (bank_q[0] == FULL)                 sel_bank = 1'b0;
      else if (bank_q[1] == FULL)                 sel_bank = 1'b1;
      else if (bank_complete)                     sel_bank = wr_bank_eff;
      else                                        sel_valid = 1'b0;
   end

   always_comb begin
      state_d      = state_q;
      rd_bank_d    = rd_bank_q;
      rd_addr_d    = rd_addr_q;
      frame_done_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (sel_valid) begin
               state_d   = S_PRIME;
               rd_bank_d = sel_bank;
               rd_addr_d = '0;
            end
         end
         S_PRIME: state_d = S_STREAM;
         S_STREAM: begin
            if (i_sink_ready) begin
               if (release_bank) state_d   = S_WAIT_SRC;
               else              rd_addr_d = rd_addr_q + 1'b1;
            end
         end
         S_WAIT_SRC: begin
            if (i_src_valid && i_src_eop) begin
               frame_done_d = 1'b1;
               if (sel_valid) begin
                  state_d   = S_PRIME;
                  rd_bank_d = sel_bank;
                  rd_addr_d = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      overflow_d = overflow_q;
      if (i_clr_status) overflow_d = 1'b0;
      if (dropped)      overflow_d = 1'b1;
      fft_error_d = i_clr_status ? 2'b00 : fft_error_q;
      if (i_src_valid) fft_error_d = fft_error_d | i_src_error;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q      <= S_IDLE;
         bank_q[0]    <= EMPTY;
         bank_q[1]    <= EMPTY;
         rd_bank_q    <= 1'b0;
         rd_addr_q    <= '0;
         wr_bank_q    <= 1'b0;
         wr_addr_q    <= '0;
         drop_q       <= 1'b0;
         first_full_q <= 1'b0;
         frame_done_q <= 1'b0;
         overflow_q   <= 1'b0;
         fft_error_q  <= 2'b00;
      end else begin
         state_q      <= state_d;
         bank_q       <= bank_d;
         rd_bank_q    <= rd_bank_d;
         rd_addr_q    <= rd_addr_d;
         wr_bank_q    <= wr_bank_d;
         wr_addr_q    <= wr_addr_d;
         drop_q       <= drop_d;
         first_full_q <= first_full_d;
         frame_done_q <= frame_done_d;
         overflow_q   <= overflow_d;
         fft_error_q  <= fft_error_d;
      end
   end

`ifdef DROP_COUNT_EN
   logic [15:0] drop_cnt_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         drop_cnt_q <= '0;
      end else if (dropped) begin
         if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 1'b1;
      end else if (i_clr_status) begin
         drop_cnt_q <= '0;
      end
   end

   assign o_drop_count = drop_cnt_q;
`endif

   pingpong_ram #(
      .N_POINTS (N_POINTS),
      .DATA_W   (DATA_W)
   ) u_ram (
      .i_clk   (i_clk),
      .i_we    (ram_we),
      .i_waddr ({wr_bank_eff, wr_addr_eff}),
      .i_wdata (i_sample),
      .i_raddr ({rd_bank_d, rd_addr_d}),
      .o_rdata (ram_rdata)
   );

   assign o_sink_valid = (state_q == S_STREAM);
   assign o_sink_sop   = o_sink_valid && (rd_addr_q == '0);
   assign o_sink_eop   = o_sink_valid && (rd_addr_q == LAST_ADDR);
   assign o_sink_data  = o_sink_valid ? ram_rdata : '0;
   assign o_frame_done = frame_done_q;
   assign o_overflow   = overflow_q;
   assign o_fft_error  = fft_error_q;
   assign o_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed self-checking bench for fft_frame_sequencer (N_POINTS = 512).
module tb_fft_frame_sequencer;

   localparam int N = 512;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_sample_valid;
   logic [15:0] i_sample;
   logic        o_sink_valid;
   logic        i_sink_ready;
   logic        o_sink_sop;
   logic        o_sink_eop;
   logic [15:0] o_sink_data;
   logic        i_src_valid;
   logic        i_src_eop;
   logic [1:0]  i_src_error;
   logic        i_clr_status;
   logic        o_frame_done;
   logic        o_overflow;
   logic [1:0]  o_fft_error;
   logic        o_busy;
`ifdef DROP_COUNT_EN
   logic [15:0] o_drop_count;
`endif

   int total    = 0;
   int pass_cnt = 0;
   int fail_cnt = 0;
   int exp_beat, bad, unstable, stalls;
   logic        stalled, prev_sop, prev_eop;
   logic [15:0] prev_data;

   fft_frame_sequencer #(
      .N_POINTS (N),
      .DATA_W   (16)
   ) dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_sample_valid (i_sample_valid),
      .i_sample       (i_sample),
      .o_sink_valid   (o_sink_valid),
      .i_sink_ready   (i_sink_ready),
      .o_sink_sop     (o_sink_sop),
      .o_sink_eop     (o_sink_eop),
      .o_sink_data    (o_sink_data),
      .i_src_valid    (i_src_valid),
      .i_src_eop      (i_src_eop),
      .i_src_error    (i_src_error),
      .i_clr_status   (i_clr_status),
      .o_frame_done   (o_frame_done),
      .o_overflow     (o_overflow),
      .o_fft_error    (o_fft_error),
      .o_busy         (o_busy)
`ifdef DROP_COUNT_EN
      ,
      .o_drop_count   (o_drop_count)
`endif
   );

   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic write_block(input logic [15:0] base, input int count);
      for (int i = 0; i < count; i++) begin
         i_sample_valid = 1'b1;
         i_sample       = 16'(base + i);
         tick();
      end
      i_sample_valid = 1'b0;
   endtask

   task automatic src_done(input string tag);
      i_src_valid = 1'b1;
      i_src_eop   = 1'b1;
      tick();
      i_src_valid = 1'b0;
      i_src_eop   = 1'b0;
      chk({tag, "_frame_done"}, o_frame_done, 1);
   endtask

   // Waits (bounded) for a frame, then takes N beats with ready high.
   task automatic recv_frame(input logic [15:0] base, input string tag);
      int waited = 0;
      int nbad   = 0;
      i_sink_ready = 1'b1;
      while (!o_sink_valid && waited < 20) begin
         tick();
         waited++;
      end
      chk({tag, "_start_valid"}, o_sink_valid, 1);
      for (int j = 0; j < N; j++) begin
         if (o_sink_valid !== 1'b1 || o_sink_data !== 16'(base + j) ||
             o_sink_sop !== (j == 0) || o_sink_eop !== (j == N - 1)) nbad++;
         tick();
      end
      chk({tag, "_bad_beats"}, nbad, 0);
      chk({tag, "_valid_after_eop"}, o_sink_valid, 0);
   endtask

   initial begin
      i_rst = 1'b1; i_sample_valid = 1'b0; i_sample = '0; i_sink_ready = 1'b1;
      i_src_valid = 1'b0; i_src_eop = 1'b0; i_src_error = 2'b00; i_clr_status = 1'b0;
      tick(); tick();
      chk("rst_valid", o_sink_valid, 0);
      chk("rst_sop_eop", {o_sink_sop, o_sink_eop}, 0);
      chk("rst_data", o_sink_data, 0);
      chk("rst_status", {o_frame_done, o_overflow, o_fft_error}, 0);
      chk("rst_busy", o_busy, 0);
      i_rst = 1'b0;
      tick();

      // Ramp with ready high; exact start latency.
      write_block(16'd0, N - 1);
      chk("t1_idle_before_last", o_busy, 0);
      write_block(16'(N - 1), 1);
      chk("t1_prime_no_valid", o_sink_valid, 0);
      chk("t1_prime_busy", o_busy, 1);
      tick();
      chk("t1_first_valid", o_sink_valid, 1);
      chk("t1_first_sop", o_sink_sop, 1);
      chk("t1_first_data", o_sink_data, 0);
      recv_frame(16'd0, "t1");
      chk("t1_busy_wait_src", o_busy, 1);
      src_done("t1");
      chk("t1_idle_after_src", o_busy, 0);
      tick();
      chk("t1_done_one_cycle", o_frame_done, 0);

      // Ramp with ready toggling every cycle.
      write_block(16'd0, N);
      exp_beat = 0; bad = 0; unstable = 0; stalls = 0; stalled = 1'b0;
      for (int c = 0; c < 3000 && exp_beat < N; c++) begin
         if (stalled && (o_sink_valid !== 1'b1 || o_sink_data !== prev_data ||
                         o_sink_sop !== prev_sop || o_sink_eop !== prev_eop)) unstable++;
         if (o_sink_valid && (o_sink_data !== 16'(exp_beat) || o_sink_sop !== (exp_beat == 0) ||
                              o_sink_eop !== (exp_beat == N - 1))) bad++;
         i_sink_ready = ~i_sink_ready;
         stalled      = o_sink_valid && !i_sink_ready;
         if (stalled) stalls++;
         if (o_sink_valid && i_sink_ready) exp_beat++;
         prev_data = o_sink_data;
         prev_sop  = o_sink_sop;
         prev_eop  = o_sink_eop;
         tick();
      end
      chk("t2_beat_count", exp_beat, N);
      chk("t2_bad_beats", bad, 0);
      chk("t2_unstable_stall", unstable, 0);
      chk("t2_valid_after_eop", o_sink_valid, 0);
      i_sink_ready = 1'b1;
      src_done("t2");

      // Overflow: both banks fill, third bank's worth dropped.
      i_sink_ready = 1'b0;
      write_block(16'd0, 2 * N);
      chk("t3_no_overflow_yet", o_overflow, 0);
      write_block(16'(2 * N), N);
      chk("t3_overflow", o_overflow, 1);
`ifdef DROP_COUNT_EN
      chk("t3_drop_count", o_drop_count, N);
`endif
      chk("t3_stalled_beat0", {o_sink_valid, o_sink_sop, o_sink_data}, {1'b1, 1'b1, 16'd0});
      recv_frame(16'd0, "t3_f0");
      src_done("t3_f0");
      recv_frame(16'(N), "t3_f1");
      src_done("t3_f1");
      write_block(16'h1000, N);
      recv_frame(16'h1000, "t3_resume");
      src_done("t3_resume");
      chk("t3_overflow_sticky", o_overflow, 1);
      i_clr_status = 1'b1;
      tick();
      i_clr_status = 1'b0;
      chk("t3_overflow_clr", o_overflow, 0);
`ifdef DROP_COUNT_EN
      chk("t3_drop_count_clr", o_drop_count, 0);
`endif

      // Error capture, sticky OR, clear, set-beats-clear.
      i_src_valid = 1'b1; i_src_error = 2'b10;
      tick();
      chk("t4_err_10", o_fft_error, 2'b10);
      i_src_error = 2'b01;
      tick();
      chk("t4_err_11", o_fft_error, 2'b11);
      i_src_valid = 1'b0; i_src_error = 2'b00; i_clr_status = 1'b1;
      tick();
      chk("t4_err_clr", o_fft_error, 2'b00);
      i_src_valid = 1'b1; i_src_error = 2'b01;
      tick();
      chk("t4_set_wins", o_fft_error, 2'b01);
      i_src_valid = 1'b0; i_src_error = 2'b00;
      tick();
      i_clr_status = 1'b0;
      chk("t4_err_clr2", o_fft_error, 2'b00);

      // Reset in the middle of a frame.
      write_block(16'h2000, N);
      i_sink_ready = 1'b1;
      tick();
      for (int j = 0; j < 200; j++) tick();
      chk("t5_beat200", o_sink_data, 16'h2000 + 16'd200);
      i_rst = 1'b1;
      #1;
      chk("t5_rst_sink", {o_sink_valid, o_sink_sop, o_sink_eop, o_sink_data}, 0);
      chk("t5_rst_misc", {o_busy, o_frame_done, o_overflow, o_fft_error}, 0);
      tick();
      i_rst = 1'b0;
      tick();
      write_block(16'h3000, N);
      recv_frame(16'h3000, "t5_fresh");
      src_done("t5");

      // Bank 1 completes in the cycle bank 0 is released.
      write_block(16'h4000, N);
      i_sink_ready = 1'b1;
      tick();
      bad = 0;
      for (int j = 0; j < N; j++) begin
         if (o_sink_valid !== 1'b1 || o_sink_data !== 16'(16'h4000 + j)) bad++;
         i_sample_valid = 1'b1;
         i_sample       = 16'(16'h5000 + j);
         tick();
      end
      i_sample_valid = 1'b0;
      chk("t6_bank0_beats", bad, 0);
      chk("t6_no_overflow", o_overflow, 0);
      chk("t6_wait_src", {o_sink_valid, o_busy}, 2'b01);
      src_done("t6_b0");
      recv_frame(16'h5000, "t6_b1");
      src_done("t6_b1");
      chk("t6_no_overflow_end", o_overflow, 0);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
